// File: rtl/multiword_add_sequencer.sv
// Multi-precision adder controller: one shared 32-bit adder, one limb per clock, LSB limb first.
// Optional macro MWADD_SUBTRACT_EN adds inSub (A - B via ~B and forced carry-in).

module adder_32bit (
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        inCarry,
  output logic [31:0] outSum,
  output logic        outCarry
);
  assign {outCarry, outSum} = {1'b0, inA} + {1'b0, inB} + {32'd0, inCarry};
endmodule

module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inStart,
  input  logic [32*WORDS-1:0]   inA,
  input  logic [32*WORDS-1:0]   inB,
  input  logic                  inCarry,
`ifdef MWADD_SUBTRACT_EN
  input  logic                  inSub,
`endif
  output logic                  outBusy,
  output logic                  outDone,
  output logic [32*WORDS-1:0]   outSum,
  output logic                  outCarry
);
  localparam int W    = 32 * WORDS;
  localparam int IDXW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_sum;
  logic              r_carry;
  logic              r_cout;
  logic [IDXW-1:0]   r_idx;
`ifdef MWADD_SUBTRACT_EN
  logic              r_sub;
`endif

  logic [IDXW+4:0]   w_base;
  logic [31:0]       w_a_limb;
  logic [31:0]       w_b_limb;
  logic [31:0]       w_limb_sum;
  logic              w_limb_cout;
  logic              w_last;
  logic              w_accept;

  assign w_base   = {r_idx, 5'd0};
  assign w_a_limb = r_a[w_base +: 32];
`ifdef MWADD_SUBTRACT_EN
  assign w_b_limb = r_sub ? ~r_b[w_base +: 32] : r_b[w_base +: 32];
`else
  assign w_b_limb = r_b[w_base +: 32];
`endif
  assign w_last   = (r_idx == IDXW'(WORDS - 1));
  assign w_accept = (r_state == IDLE) && inStart;

  adder_32bit u_adder (
    .inA      (w_a_limb),
    .inB      (w_b_limb),
    .inCarry  (r_carry),
    .outSum   (w_limb_sum),
    .outCarry (w_limb_cout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (inStart) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
`ifdef MWADD_SUBTRACT_EN
      r_sub   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= inA;
      r_b     <= inB;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
`ifdef MWADD_SUBTRACT_EN
      r_sub   <= inSub;
      r_carry <= inSub | inCarry;
`else
      r_carry <= inCarry;
`endif
    end else if (r_state == RUN) begin
      r_sum[w_base +: 32] <= w_limb_sum;
      r_carry             <= w_limb_cout;
      // Hold the index on the top limb so it never wraps.
      if (w_last) r_cout <= w_limb_cout;
      else        r_idx  <= r_idx + IDXW'(1);
    end
  end

  assign outBusy  = (r_state != IDLE);
  assign outDone  = (r_state == DONE);
  assign outSum   = r_sum;
  assign outCarry = r_cout;
endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Multi-precision adder controller. Time-shares one adder_32bit instance to add operands of WORDS×32 bits, one 32-bit limb per clock, least-significant limb first.
- Latches operands on a start pulse, steps the limb index, and registers the carry between limbs.
- Returns the full sum and final carry with a one-cycle done pulse.
- Sits between ALU/bignum control logic and the shared 32-bit adder datapath.

Parameters:
- WORDS, 4, number of 32-bit limbs per operand (legal range 2..16); operand width W = 32*WORDS

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- inStart  input  1  request a new addition; accepted only in IDLE
- inA  input  W  operand A, sampled on the accepting edge only
- inB  input  W  operand B, sampled on the accepting edge only
- inCarry  input  1  initial carry-in, sampled on the accepting edge only
- outBusy  output  1  high whenever state != IDLE
- outDone  output  1  one-cycle pulse: result valid
- outSum  output  W  W-bit sum
- outCarry  output  1  carry out of the top limb

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, limb index=0, carry register=0, operand registers=0, outSum=0, outCarry=0, outDone=0, outBusy=0.
- Reset mid-operation aborts immediately. No outDone is produced. All outputs return to their reset values on that edge.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on an edge with inStart=1:
  - latch inA, inB, inCarry;
  - index=0;
  - clear outSum to 0 and outCarry to 0.
- RUN: on each edge, the adder output for limb[index] (A limb, B limb, carry register) is written to outSum[32*index +: 32]. The adder's outCarry is written to the carry register, and index increments.
- RUN → DONE on the edge that processes index=WORDS-1. outCarry takes the final adder carry on that same edge.
- DONE: outDone=1 for exactly this one cycle. The next edge goes to IDLE unconditionally.
- Latency: if start is accepted at edge k, outDone is high in the cycle following edge k+WORDS. The earliest next acceptance is edge k+WORDS+2.
- inStart while RUN or DONE is ignored: no queueing and no error. Operand inputs may change freely after the accepting edge.
- outSum and outCarry hold stable from DONE until the next accepted start.
- Lower limbs of outSum become final progressively during RUN. Consumers use only the outDone/!outBusy values.
- Arithmetic is modulo 2^W; the carry beyond the top limb appears only on outCarry.
- The datapath is exactly one adder_32bit instance. No other adders are used for the sum.
- Index counter width is $clog2(WORDS). It does not wrap during valid operation; it resets to 0 on accept.

Optional Feature:
- Macro MWADD_SUBTRACT_EN.
- When defined: an extra input port inSub (1 bit) is added and sampled on the accepting edge.
  - inSub=1: the B limbs feed the adder inverted (~B), and the initial carry is forced to 1, ignoring inCarry. The result is A−B.
  - outCarry=1 means no borrow (A≥B unsigned); outCarry=0 means borrow.
  - inSub=0 behaves exactly as the base addition.
- When undefined: there is no inSub port and the block performs addition only, as described above.

Test Plan:
- WORDS=4, A=2^128−1, B=1, inCarry=0 → outSum=0, outCarry=1. outDone high exactly in the cycle after edge k+4, and outBusy high for 5 cycles.
- A=0x00000000_00000000_00000000_FFFFFFFF, B=0x1, inCarry=0 → outSum=0x00000000_00000000_00000001_00000000, outCarry=0. Checks the inter-limb carry register.
- A=0x80000000_00000000_00000000_00000000, B=same, inCarry=1 → outSum=0x1, outCarry=1.
- Start accepted; inStart re-pulsed with different operands at edges k+1 and k+4 → both ignored, the result matches the first operands, and only one outDone occurs.
- Start accepted; rst=1 at edge k+2 → outBusy=0, outSum=0, outCarry=0, and no outDone follows. A new start after reset completes normally.
- With MWADD_SUBTRACT_EN: A=5, B=3, inSub=1 → outSum=2, outCarry=1. A=3, B=5, inSub=1 → outSum=2^128−2, outCarry=0.
